sdram_ctrl: RTL

Single-port SDR SDRAM controller that serves the 16-bit CPU address bus with 8-bit reads and writes, hiding SDRAM power-up initialisation and periodic auto-refresh. It sits between the CPU bus interface in `top` and the SDRAM pins. It uses one ACTIVATE plus READA/WRITEA (auto-precharge) per access, so no rows are ever left open.

---
 rtl/sdram_defs.sv | 51 +++++
 rtl/sdram_ctrl_if.sv | 18 +
 rtl/sdram_refresh_timer.sv | 55 +++++
 rtl/sdram_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_defs.sv
// Shared definitions for the SDR SDRAM controller.
// Holds the SDRAM command encodings ({cs_n, ras_n, cas_n, we_n}), the
// controller state encoding, and helpers that build the mode-register word
// and split a CPU address into row and column.
package sdram_defs;

    // SDRAM command encodings, bit order {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    // Width of the shared wait counter and of the refresh counter
    localparam int WAIT_W = 16;

    typedef enum logic [3:0] {
        ST_INIT_WAIT = 4'd0,
        ST_INIT_PRE  = 4'd1,
        ST_INIT_REF1 = 4'd2,
        ST_INIT_REF2 = 4'd3,
        ST_INIT_MRS  = 4'd4,
        ST_IDLE      = 4'd5,
        ST_ACT       = 4'd6,
        ST_RW        = 4'd7,
        ST_CAS_WAIT  = 4'd8,
        ST_PRE_WAIT  = 4'd9,
        ST_REFRESH   = 4'd10
    } state_t;

    // Mode register: burst length 1, sequential burst, given CAS latency
    function automatic logic [11:0] mode_word(input int unsigned cas_lat);
        logic [2:0] cl;
        cl = cas_lat[2:0];
        return {5'b00000, cl, 1'b0, 3'b000};
    endfunction

    // Row address driven with ACTIVATE
    function automatic logic [11:0] row_addr(input logic [15:0] cpu_addr);
        return {6'b000000, cpu_addr[13:8]};
    endfunction

    // Column address driven with READ/WRITE; A10 set selects auto-precharge
    function automatic logic [11:0] col_addr(input logic [15:0] cpu_addr);
        return {4'b0100, cpu_addr[7:0]};
    endfunction

endpackage

// File: rtl/sdram_ctrl_if.sv
// CPU-side bus of the SDRAM controller.
//   req/we/addr/wdata : access request from the CPU, held until ack
//   rdata             : read data, valid in the ack cycle and held after
//   ack               : one-cycle completion pulse
// master modport is the CPU side, slave modport is the controller side.
interface sdram_ctrl_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;

    modport master (output req, output we, output addr, output wdata,
                    input rdata, input ack);
    modport slave  (input req, input we, input addr, input wdata,
                    output rdata, output ack);
endinterface

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh request timer.
// A free-running down-counter runs while enable is high. Each time it
// reaches zero it reloads REFRESH_INTERVAL-1 and raises pending. Only one
// request is remembered: an expiry while pending is already set is absorbed.
// Ports: clk_in, reset (async, active high), enable (count), clear (drop
// pending once the refresh has been done), pending (refresh owed).
module sdram_refresh_timer
    import sdram_defs::*;
#(
    parameter int REFRESH_INTERVAL = 115
) (
    input  logic clk_in,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic pending
);

    localparam logic [WAIT_W-1:0] RELOAD = WAIT_W'(REFRESH_INTERVAL - 1);

    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              expire_s;

    // Next counter value and pending flag; a new expiry wins over clear
    always_comb begin
        expire_s  = enable && (cnt_q == {WAIT_W{1'b0}});
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (expire_s) begin
            cnt_d     = RELOAD;
            pending_d = 1'b1;
        end else if (enable) begin
            cnt_d     = cnt_q - WAIT_W'(1);
            pending_d = clear ? 1'b0 : pending_q;
        end else begin
            cnt_d     = cnt_q;
            pending_d = clear ? 1'b0 : pending_q;
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/sdram_ctrl.sv
// Single-port SDR SDRAM controller for 8-bit CPU accesses on a 16-bit bus.
// Runs the power-up sequence (NOP wait, PRECHARGE ALL, two AUTO REFRESH,
// MODE REGISTER SET), then serves each access with ACTIVATE followed by
// READA/WRITEA so no row is ever left open, and inserts auto-refresh when
// the refresh timer asks for it.
// Ports: clk_in, reset (async, active high); bus (CPU request/ack bus,
// slave side); init_done; SDRAM pins sd_cke, sd_cs_n, sd_ras_n, sd_cas_n,
// sd_we_n, sd_ba, sd_a, sd_dq_out, sd_dq_oe, sd_dq_in, sd_dqm.
// Every pin is driven from a register.
module sdram_ctrl
    import sdram_defs::*;
#(
    parameter int INIT_CYCLES      = 1475,
    parameter int REFRESH_INTERVAL = 115,
    parameter int TRCD             = 2,
    parameter int CAS              = 2,
    parameter int TRP              = 2,
    parameter int TWR              = 2,
    parameter int TRFC             = 4,
    parameter int TMRD             = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    sdram_ctrl_if.slave       bus,
    output logic              init_done,
    output logic              sd_cke,
    output logic              sd_cs_n,
    output logic              sd_ras_n,
    output logic              sd_cas_n,
    output logic              sd_we_n,
    output logic [1:0]        sd_ba,
    output logic [11:0]       sd_a,
    output logic [7:0]        sd_dq_out,
    output logic              sd_dq_oe,
    input  logic [7:0]        sd_dq_in,
    output logic              sd_dqm
);

    // Wait-counter load values: a load of N-1 gives N cycles in the state
    localparam logic [WAIT_W-1:0] W_INIT = WAIT_W'(INIT_CYCLES);
    localparam logic [WAIT_W-1:0] W_TRCD = WAIT_W'(TRCD - 1);
    localparam logic [WAIT_W-1:0] W_CAS  = WAIT_W'(CAS - 1);
    localparam logic [WAIT_W-1:0] W_TRP  = WAIT_W'(TRP - 1);
    localparam logic [WAIT_W-1:0] W_WRP  = WAIT_W'(TWR + TRP - 1);
    localparam logic [WAIT_W-1:0] W_TRFC = WAIT_W'(TRFC - 1);
    localparam logic [WAIT_W-1:0] W_TMRD = WAIT_W'(TMRD - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [1:0]        ba_q, ba_d;
    logic [11:0]       a_q, a_d;
    logic [7:0]        dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              dqm_q, dqm_d;
    logic              cke_q, cke_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              init_done_q, init_done_d;

    logic              wait_done_s;
    logic              ref_pending_s;
    logic              ref_clear_s;

    assign wait_done_s = (wait_q == {WAIT_W{1'b0}});

    // Refresh timer starts counting once the controller first reaches IDLE
    sdram_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk_in  (clk_in),
        .reset   (reset),
        .enable  (init_done_q),
        .clear   (ref_clear_s),
        .pending (ref_pending_s)
    );

    // State, wait counter and all pin registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT_WAIT;
            wait_q      <= W_INIT;
            cmd_q       <= CMD_DESEL;
            ba_q        <= 2'b00;
            a_q         <= 12'h000;
            dq_out_q    <= 8'h00;
            dq_oe_q     <= 1'b0;
            dqm_q       <= 1'b1;
            cke_q       <= 1'b0;
            rdata_q     <= 8'h00;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            a_q         <= a_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            dqm_q       <= dqm_d;
            cke_q       <= cke_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
        end
    end

    // Next state and shared wait counter
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        ref_clear_s = 1'b0;
        case (state_q)
            ST_INIT_WAIT: begin
                if (wait_done_s) begin
                    state_d = ST_INIT_PRE;
                    wait_d  = W_TRP;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_INIT_PRE: begin
                if (wait_done_s) begin
                    state_d = ST_INIT_REF1;
                    wait_d  = W_TRFC;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_INIT_REF1: begin
                if (wait_done_s) begin
                    state_d = ST_INIT_REF2;
                    wait_d  = W_TRFC;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_INIT_REF2: begin
                if (wait_done_s) begin
                    state_d = ST_INIT_MRS;
                    wait_d  = W_TMRD;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_INIT_MRS: begin
                if (wait_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_IDLE: begin
                // An owed refresh always goes before a CPU access
                if (ref_pending_s) begin
                    state_d = ST_REFRESH;
                    wait_d  = W_TRFC;
                end else if (bus.req) begin
                    state_d = ST_ACT;
                    wait_d  = W_TRCD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACT: begin
                if (wait_done_s) begin
                    state_d = ST_RW;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_RW: begin
                // Writes go straight to recovery; reads wait out CAS latency
                if (bus.we) begin
                    state_d = ST_PRE_WAIT;
                    wait_d  = W_WRP;
                end else begin
                    state_d = ST_CAS_WAIT;
                    wait_d  = W_CAS;
                end
            end
            ST_CAS_WAIT: begin
                if (wait_done_s) begin
                    state_d = ST_PRE_WAIT;
                    wait_d  = W_TRP;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_PRE_WAIT: begin
                if (wait_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_REFRESH: begin
                if (wait_done_s) begin
                    state_d     = ST_IDLE;
                    ref_clear_s = 1'b1;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT_WAIT;
                wait_d  = W_INIT;
            end
        endcase
    end

    // Pin values for the next cycle; any cycle without a command is a NOP
    always_comb begin
        cmd_d       = CMD_NOP;
        ba_d        = 2'b00;
        a_d         = 12'h000;
        dq_out_d    = 8'h00;
        dq_oe_d     = 1'b0;
        dqm_d       = dqm_q;
        cke_d       = 1'b1;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT_WAIT: begin
                if (wait_done_s) begin
                    cmd_d = CMD_PRE;
                    a_d   = 12'h400;  // A10 = precharge all banks
                end else begin
                    cmd_d = CMD_NOP;
                end
            end
            ST_INIT_PRE, ST_INIT_REF1: begin
                if (wait_done_s) begin
                    cmd_d = CMD_REF;
                end else begin
                    cmd_d = CMD_NOP;
                end
            end
            ST_INIT_REF2: begin
                if (wait_done_s) begin
                    cmd_d = CMD_MRS;
                    a_d   = mode_word(CAS);
                end else begin
                    cmd_d = CMD_NOP;
                end
            end
            ST_INIT_MRS: begin
                if (wait_done_s) begin
                    init_done_d = 1'b1;
                    dqm_d       = 1'b0;
                end else begin
                    init_done_d = init_done_q;
                end
            end
            ST_IDLE: begin
                if (ref_pending_s) begin
                    cmd_d = CMD_REF;
                end else if (bus.req) begin
                    cmd_d = CMD_ACT;
                    ba_d  = bus.addr[15:14];
                    a_d   = row_addr(bus.addr);
                end else begin
                    cmd_d = CMD_NOP;
                end
            end
            ST_ACT: begin
                if (wait_done_s) begin
                    ba_d = bus.addr[15:14];
                    a_d  = col_addr(bus.addr);
                    if (bus.we) begin
                        // Burst length 1: data is on the pad with WRITEA only
                        cmd_d    = CMD_WRITE;
                        dq_oe_d  = 1'b1;
                        dq_out_d = bus.wdata;
                    end else begin
                        cmd_d = CMD_READ;
                    end
                end else begin
                    cmd_d = CMD_NOP;
                end
            end
            ST_RW: begin
                if (bus.we) begin
                    ack_d = 1'b1;
                end else begin
                    ack_d = 1'b0;
                end
            end
            ST_CAS_WAIT: begin
                if (wait_done_s) begin
                    rdata_d = sd_dq_in;
                    ack_d   = 1'b1;
                end else begin
                    ack_d = 1'b0;
                end
            end
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
    end

    assign sd_cs_n   = cmd_q[3];
    assign sd_ras_n  = cmd_q[2];
    assign sd_cas_n  = cmd_q[1];
    assign sd_we_n   = cmd_q[0];
    assign sd_ba     = ba_q;
    assign sd_a      = a_q;
    assign sd_dq_out = dq_out_q;
    assign sd_dq_oe  = dq_oe_q;
    assign sd_dqm    = dqm_q;
    assign sd_cke    = cke_q;
    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign init_done = init_done_q;

endmodule
